// File: rtl/cpu_bus_pkg.sv
// Shared SM83 bus types: T-phase encoding, latched bus command,
// open-bus default and the memory window offset helper.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_T1   = 3'd1,
    PH_T2   = 3'd2,
    PH_T3   = 3'd3,
    PH_T4   = 3'd4
  } t_phase_e;

  typedef struct packed {
    logic [15:0] adr;
    logic        rd;
    logic        wr;
  } bus_cmd_t;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hff;

  // 17-bit so an address below base lands with bit 16 set (no wrap)
  function automatic logic [16:0] win_off(
    input logic [15:0] adr,
    input logic [15:0] base
  );
    return {1'b0, adr} - {1'b0, base};
  endfunction

endpackage

// File: rtl/cpu_mem_responder_ram.sv
// Synchronous byte RAM for the SM83 memory responder:
// one registered read port, one write port.
module cpu_mem_responder_ram
  #(
    parameter int ADDR_W = 8
  )
  (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
  );

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// SM83 memory-side responder: T-phase FSM, command latch, window decode.
// Optional bus protocol checker (output bus_err) under BUS_CHECK_EN.
module cpu_mem_responder
  import cpu_bus_pkg::*;
  #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] BASE     = 16'hff80,
    parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
  )
  (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ce,
    input  logic        cpu_t1,
    input  logic [15:0] cpu_adr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        rd_done,
    output logic        wr_done,
`ifdef BUS_CHECK_EN
    output logic        bus_err,
`endif
    output logic [15:0] last_adr
  );

  t_phase_e          phase;
  t_phase_e          phase_nx;
  bus_cmd_t          cmd;
  logic              hit;
  logic [ADDR_W-1:0] idx;
  logic [16:0]       off;
  logic              hit_c;
  logic              is_rd;
  logic              is_wr;
  logic              ph_t1;
  logic              ph_t2;
  logic              ph_t3;
  logic              ph_t4;
  logic              ram_re;
  logic              ram_we;
  logic [7:0]        ram_q;

  assign off   = win_off(cpu_adr, BASE);
  assign hit_c = (off >> ADDR_W) == 17'd0;

  // rd&&wr together is served as a read
  assign is_rd = cmd.rd;
  assign is_wr = cmd.wr & ~cmd.rd;

  assign ph_t1 = phase == PH_T1;
  assign ph_t2 = phase == PH_T2;
  assign ph_t3 = phase == PH_T3;
  assign ph_t4 = phase == PH_T4;

  assign ram_re = ce & ph_t1 & is_rd & ~cpu_t1;
  assign ram_we = ce & ph_t4 & is_wr & hit;

  assign last_adr = cmd.adr;

  always_comb begin
    phase_nx = phase;
    if (cpu_t1) begin
      phase_nx = PH_T1;
    end else begin
      unique case (1'b1)
        ph_t1:   phase_nx = PH_T2;
        ph_t2:   phase_nx = PH_T3;
        ph_t3:   phase_nx = PH_T4;
        ph_t4:   phase_nx = PH_IDLE;
        default: phase_nx = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase   <= PH_IDLE;
      cmd     <= '0;
      hit     <= 1'b0;
      idx     <= '0;
      cpu_din <= OPEN_BUS;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
    end else if (ce) begin
      phase   <= phase_nx;
      rd_done <= ph_t3 & is_rd & ~cpu_t1;
      wr_done <= ph_t4 & is_wr;
      if (cpu_t1) begin
        cmd <= '{adr: cpu_adr, rd: cpu_rd, wr: cpu_wr};
        hit <= hit_c;
        idx <= off[ADDR_W-1:0];
      end
      if (ph_t2 && is_rd && !cpu_t1) begin
        cpu_din <= hit ? ram_q : OPEN_BUS;
      end
    end
  end

  cpu_mem_responder_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx),
    .wdata (cpu_dout),
    .re    (ram_re),
    .raddr (idx),
    .rdata (ram_q)
  );

`ifdef BUS_CHECK_EN
  logic viol;

  always_comb begin
    viol = 1'b0;
    if (cpu_t1) begin
      viol = (cpu_rd & cpu_wr) | ph_t1 | ph_t2 | ph_t3;
    end else if (ph_t2 || ph_t3 || ph_t4) begin
      viol = (cpu_adr != cmd.adr)
           | (cpu_rd != cmd.rd)
           | (cpu_wr != cmd.wr);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus_err <= 1'b0;
    end else if (ce && viol) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule
